// File: rtl/signed_operand_arbiter_pkg.sv
// Shared definitions for the signed operand arbiter: operand width, the issue
// stage payload and the widened add/subtract used by the result stage.
package signed_operand_arbiter_pkg;

  localparam int WIDTH    = 8;
  // Tag field is sized for the largest supported requester count (16).
  localparam int ID_MAX_W = 4;

  typedef struct packed {
    logic signed [WIDTH-1:0] a;
    logic signed [WIDTH-1:0] b;
    logic                    sub;
    logic [ID_MAX_W-1:0]     id;
  } s1_payload_t;

  // One extra bit of headroom means neither A+B nor A-B can overflow.
  function automatic logic signed [WIDTH:0] addsub(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b,
    input logic                    sub
  );
    logic signed [WIDTH:0] ax;
    logic signed [WIDTH:0] bx;
    ax = $signed({a[WIDTH-1], a});
    bx = $signed({b[WIDTH-1], b});
    return sub ? (ax - bx) : (ax + bx);
  endfunction

endpackage

// File: rtl/signed_operand_arbiter_rr_arbiter.sv
// N-input round-robin arbiter: grants the first request at or after the
// pointer (cyclic search), then moves the pointer just past the winner.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           enable,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx,
  output logic           grant_valid
);

  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;

  always_comb begin
    int             cand;
    logic [IDW-1:0] cand_idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = IDW'(cand);
      if (enable && !grant_valid && req[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign grant = grant_valid ? (N'(1) << grant_idx) : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (grant_valid) begin
      ptr_d = (grant_idx == IDW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/signed_operand_arbiter.sv
// Shares one 2-stage signed add/subtract pipeline between N requesters under
// round-robin arbitration; results come back tagged with the requester id.
module signed_operand_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = signed_operand_arbiter_pkg::WIDTH,
  parameter int IDW   = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req_valid,
  output logic [N-1:0]          req_ready,
  input  logic [N*WIDTH-1:0]    req_a,
  input  logic [N*WIDTH-1:0]    req_b,
  input  logic [N-1:0]          req_sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [WIDTH:0] out_result,
  output logic [IDW-1:0]        out_id,
  output logic                  busy
);

  import signed_operand_arbiter_pkg::*;

  logic                  adv1;
  logic                  adv2;
  logic [N-1:0]          grant;
  logic [IDW-1:0]        grant_idx;
  logic                  grant_valid;

  s1_payload_t           s1_q;
  s1_payload_t           s1_d;
  logic                  s1_valid_q;
  logic                  s1_valid_d;
  logic                  s2_valid_q;
  logic                  s2_valid_d;
  logic signed [WIDTH:0] s2_result_q;
  logic signed [WIDTH:0] s2_result_d;
  logic [IDW-1:0]        s2_id_q;
  logic [IDW-1:0]        s2_id_d;
  logic                  unused_id_bits;

  assign adv2 = !s2_valid_q || out_ready;
  assign adv1 = !s1_valid_q || adv2;

  // Grants are suppressed while reset is held so nothing is handshaken away.
  rr_arbiter #(
    .N   (N),
    .IDW (IDW)
  ) u_rr_arbiter (
    .clk         (clk),
    .rst         (rst),
    .req         (req_valid),
    .enable      (adv1 && !rst),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign req_ready = grant;

  // ---- S0 -> S1: capture the granted requester's operands
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (adv1) begin
      s1_valid_d = grant_valid;
      if (grant_valid) begin
        s1_d.a   = req_a[int'(grant_idx)*WIDTH +: WIDTH];
        s1_d.b   = req_b[int'(grant_idx)*WIDTH +: WIDTH];
        s1_d.sub = req_sub[grant_idx];
        s1_d.id  = ID_MAX_W'(grant_idx);
      end
    end
  end

  // ---- S1 -> S2: widened add/subtract into the output register
  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_id_d     = s2_id_q;
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_result_d = addsub(s1_q.a, s1_q.b, s1_q.sub);
        s2_id_d     = s1_q.id[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_id_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_id_q     <= s2_id_d;
    end
  end

  // Operand payload is qualified by s1_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    s1_q <= s1_d;
  end

  // Tag bits above IDW are always zero.
  assign unused_id_bits = ^s1_q.id;

  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_id     = s2_id_q;
  assign busy       = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_signed_operand_arbiter.sv
// Directed bench for signed_operand_arbiter with a queue-based reference model
// checked every cycle, plus literal expectations for each scenario.
module tb_signed_operand_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [N*W-1:0]       req_a;
  logic [N*W-1:0]       req_b;
  logic [N-1:0]         req_sub;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [W:0]    out_result;
  logic [IDW-1:0]       out_id;
  logic                 busy;

  always #5 clk = ~clk;

  signed_operand_arbiter #(.N(N), .WIDTH(W), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sub    (req_sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_id     (out_id),
    .busy       (busy)
  );

  // Requester-side drive values
  logic [N-1:0]        tvalid;
  logic [N-1:0]        tsub;
  logic signed [W-1:0] ta [N];
  logic signed [W-1:0] tb_op [N];

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = ta[i];
      req_b[i*W +: W] = tb_op[i];
    end
  end
  assign req_valid = tvalid;
  assign req_sub   = tsub;

  typedef struct {
    int                  r;
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    logic                sub;
  } op_t;
  op_t pend[$];

  typedef struct {
    int id;
    int res;
    int stg;
  } ent_t;
  ent_t mq[$];
  int   mptr;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int glog[$];
  int gcyc[$];
  int olog_id[$];
  int olog_res[$];
  int ocyc[$];
  int exp_q[$];

  logic [N-1:0] acc_n = '0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_seq(input string nm, input int got[$], input int ex[$]);
    check({nm, "_len"}, got.size(), ex.size());
    for (int k = 0; k < ex.size() && k < got.size(); k++)
      check($sformatf("%s[%0d]", nm, k), got[k], ex[k]);
  endtask

  // Reference arbitration: first valid requester cyclically from p.
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic bit m_has2();
    return mq.size() > 0 && mq[0].stg == 2;
  endfunction

  function automatic bit m_has1();
    return mq.size() > 0 && mq[mq.size()-1].stg == 1;
  endfunction

  function automatic bit m_can_accept();
    return !m_has1() || !m_has2() || out_ready;
  endfunction

  // Model: entries age from the issue slot into the result slot, leave on out_ready.
  always @(posedge clk or posedge rst) begin
    int   g;
    bit   ca;
    ent_t e;
    if (rst) begin
      mq.delete();
      mptr = 0;
    end else begin
      g  = pick(tvalid, mptr);
      ca = m_can_accept();
      if (m_has2() && out_ready) void'(mq.pop_front());
      if (mq.size() == 1 && mq[0].stg == 1) mq[0].stg = 2;
      if (ca && g >= 0) begin
        e.id  = g;
        e.res = tsub[g] ? (int'(ta[g]) - int'(tb_op[g])) : (int'(ta[g]) + int'(tb_op[g]));
        e.stg = 1;
        mq.push_back(e);
        mptr = (g + 1) % N;
      end
    end
  end

  always @(posedge clk) cyc++;

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic [N-1:0] er;
    int           g;
    if (rst) begin
      check("rst_req_ready", int'(req_ready), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_busy", int'(busy), 0);
    end else begin
      er = '0;
      g  = pick(tvalid, mptr);
      if (m_can_accept() && g >= 0) er[g] = 1'b1;
      check("req_ready", int'(req_ready), int'(er));
      check("out_valid", int'(out_valid), int'(m_has2()));
      check("busy", int'(busy), int'(mq.size() > 0));
      if (m_has2()) begin
        check("out_result", int'(out_result), mq[0].res);
        check("out_id", int'(out_id), mq[0].id);
      end
    end
  end

  // Handshake capture and logging
  always @(negedge clk) begin
    acc_n = rst ? '0 : (req_ready & req_valid);
    if (!rst) begin
      for (int i = 0; i < N; i++)
        if (acc_n[i]) begin
          glog.push_back(i);
          gcyc.push_back(cyc);
        end
      if (out_valid && out_ready) begin
        olog_id.push_back(int'(out_id));
        olog_res.push_back(int'(out_result));
        ocyc.push_back(cyc);
      end
    end
  end

  // Requester driver: present each requester's oldest pending op, hold until taken.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      int found;
      if (acc_n[i]) begin
        found = -1;
        for (int k = 0; k < pend.size(); k++)
          if (found < 0 && pend[k].r == i) found = k;
        if (found >= 0) pend.delete(found);
      end
      found = -1;
      for (int k = 0; k < pend.size(); k++)
        if (found < 0 && pend[k].r == i) found = k;
      if (found >= 0) begin
        tvalid[i] = 1'b1;
        ta[i]     = pend[found].a;
        tb_op[i]  = pend[found].b;
        tsub[i]   = pend[found].sub;
      end else begin
        tvalid[i] = 1'b0;
      end
    end
  end

  task automatic push(input int r, input int a, input int b, input logic sub);
    op_t o;
    o.r   = r;
    o.a   = W'(a);
    o.b   = W'(b);
    o.sub = sub;
    pend.push_back(o);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_logs();
    glog.delete();
    gcyc.delete();
    olog_id.delete();
    olog_res.delete();
    ocyc.delete();
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (n < 64 && (pend.size() > 0 || mq.size() > 0)) begin
      tick(1);
      n++;
    end
    check({nm, "_drain_in_time"}, int'(n < 64), 1);
  endtask

  initial begin
    tvalid    = '1;
    tsub      = '0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      ta[i]    = 8'sd1;
      tb_op[i] = 8'sd1;
    end
    #1;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_result", int'(out_result), 0);
    check("reset_out_id", int'(out_id), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_req_ready", int'(req_ready), 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    // Single request from requester 2
    clear_logs();
    push(2, 5, -3, 1'b0);
    wait_drain("single");
    exp_q = {2};
    check_seq("single_grant", glog, exp_q);
    exp_q = {2};
    check_seq("single_out_id", olog_id, exp_q);
    exp_q = {2};
    check_seq("single_out_res", olog_res, exp_q);
    if (ocyc.size() > 0 && gcyc.size() > 0) check("single_latency", ocyc[0] - gcyc[0], 2);
    else check("single_latency_seen", 0, 1);

    // Extreme operands
    clear_logs();
    push(0, -128, 127, 1'b1);
    push(0, 127, 127, 1'b0);
    wait_drain("extreme");
    exp_q = {-255, 254};
    check_seq("extreme_res", olog_res, exp_q);

    // Fairness from a fresh pointer
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    clear_logs();
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < N; i++)
        push(i, i*10 + j, j, j[0]);
    wait_drain("fair");
    exp_q = {0, 1, 2, 3, 0, 1, 2, 3};
    check_seq("fair_grant", glog, exp_q);
    check_seq("fair_out_id", olog_id, exp_q);
    exp_q = {0, 10, 20, 30, 0, 10, 20, 30};
    check_seq("fair_out_res", olog_res, exp_q);
    for (int k = 1; k < gcyc.size(); k++)
      check("fair_back_to_back", gcyc[k] - gcyc[0], k);

    // Back-pressure with a full pipeline
    clear_logs();
    out_ready = 1'b0;
    push(1, 10, 3, 1'b0);
    push(1, -7, -9, 1'b1);
    push(1, 100, -100, 1'b1);
    tick(3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_req_ready", int'(req_ready), 0);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_out_result", int'(out_result), 13);
      check("bp_out_id", int'(out_id), 1);
    end
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_drain("bp");
    exp_q = {13, 2, 200};
    check_seq("bp_out_res", olog_res, exp_q);
    exp_q = {1, 1, 1};
    check_seq("bp_out_id", olog_id, exp_q);

    // Wrap and skip: pointer moved to 3 by one grant to requester 2
    clear_logs();
    push(2, 1, 1, 1'b0);
    wait_drain("wrap_setup");
    clear_logs();
    push(1, 4, 1, 1'b0);
    push(1, 4, 2, 1'b0);
    push(3, -4, 1, 1'b0);
    push(3, -4, 2, 1'b0);
    wait_drain("wrap");
    exp_q = {3, 1, 3, 1};
    check_seq("wrap_grant", glog, exp_q);
    exp_q = {-3, 5, -2, 6};
    check_seq("wrap_out_res", olog_res, exp_q);

    // Reset with two entries in flight
    clear_logs();
    out_ready = 1'b0;
    push(1, 1, 2, 1'b0);
    push(2, 3, 4, 1'b0);
    tick(3);
    check("midrst_busy_before", int'(busy), 1);
    check("midrst_valid_before", int'(out_valid), 1);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_busy", int'(busy), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    pend.delete();
    clear_logs();
    out_ready = 1'b1;
    push(3, 2, 2, 1'b0);
    push(1, 2, 2, 1'b1);
    wait_drain("post_rst");
    exp_q = {1, 3};
    check_seq("post_rst_grant", glog, exp_q);
    exp_q = {0, 4};
    check_seq("post_rst_res", olog_res, exp_q);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/signed_operand_arbiter.md
Name: signed_operand_arbiter

Overview:
- Shares one pipelined signed add/subtract datapath between N requesters.
- Each requester presents a signed operand pair and an op bit under a valid/ready handshake.
- A round-robin arbiter issues at most one request per cycle into a 2-stage pipeline. Results return on a single output channel tagged with the requester id.
- Sits between the operand-producing modules and the shared arithmetic resource. Operand width comes from the shared package constant.

Parameters:
- N, 4, number of requesters (2..16)
- WIDTH, 8, signed operand width (the package WIDTH constant)
- IDW, $clog2(N), width of the requester id tag

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  N  request valid per requester
- req_ready  output  N  request accepted this cycle (one-hot or zero)
- req_a  input  N*WIDTH  signed operand A; requester i at slice [i*WIDTH +: WIDTH]
- req_b  input  N*WIDTH  signed operand B, same packing
- req_sub  input  N  1 = A-B, 0 = A+B
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_result  output  WIDTH+1  signed result, sign-extended, never overflows
- out_id  output  IDW  requester index that produced the result
- busy  output  1  any stage holds a valid entry

Behaviour:
- Reset (async assert, sync release):
  - s1_valid = 0, s2_valid (out_valid) = 0
  - rr_ptr = 0
  - out_result = 0, out_id = 0, req_ready = 0, busy = 0
- Pipeline: S1 issue register (a, b, sub, id); S2 result register, which drives the out_* ports.
- Latency: request accepted in cycle t -> out_valid in cycle t+2 if unstalled.
- Stall rules:
  - adv2 = !s2_valid || out_ready
  - adv1 = !s1_valid || adv2
  - S2 loads S1 when adv2. S2 clears when out_ready is high and S1 is empty.
- Arbitration:
  - When adv1, grant the first asserted req_valid at or after rr_ptr, searching cyclically upward with wrap N-1 -> 0.
  - req_ready[g] = 1 only for the granted requester; all zero when !adv1 or no valid request.
  - req_ready is combinational from req_valid and state.
- Pointer: on grant g, rr_ptr <= (g+1) mod N. No grant leaves it unchanged.
- Handshake: transfer occurs when req_valid[i] && req_ready[i]. Requesters must hold their operands stable while valid and not ready.
- Arithmetic: both operands sign-extended to WIDTH+1, then added or subtracted, computed in S1->S2.
  - Example: -128 - 127 = -255, representable in 9 bits.
- Output: out_result/out_id hold stable while out_valid && !out_ready.
- Simultaneous pop and push: the full pipeline sustains one result per cycle while out_ready stays high.
- Back-pressure: if out_ready is low with S1 and S2 full, all req_ready = 0 and no data is lost or duplicated.
- busy = s1_valid | s2_valid.
- Reset mid-operation: in-flight entries are discarded, out_valid drops immediately (async), and rr_ptr returns to 0.
- An id with no request never appears at the output.

Decomposition:
- Shared package holds:
  - WIDTH localparam
  - typedef of the S1 payload struct: signed a, signed b, sub, id
  - function computing the sign-extended add/sub result
- One natural sub-module: rr_arbiter (N-input round-robin, ports: req, enable, grant one-hot, grant_idx, pointer update). It is reusable by other schedulers.

Test Plan:
- Single request: requester 2 sends a=5, b=-3, sub=0 with out_ready=1 -> req_ready[2] same cycle; two cycles later out_valid=1, out_result=2, out_id=2.
- Extremes: a=-128, b=127, sub=1 -> out_result=-255 (9'h101). a=127, b=127, sub=0 -> 254.
- Fairness: all four requesters held valid for 8 cycles with out_ready=1, starting rr_ptr=0 -> grants 0,1,2,3,0,1,2,3 and out_id follows the same order at 2-cycle lag.
- Back-pressure: fill the pipeline, hold out_ready=0 for 5 cycles -> req_ready all 0, out_result/out_id stable. Release -> results drain in order with no loss or duplicates.
- Wrap and skip: rr_ptr=3, only requesters 1 and 3 valid -> grant 3, then 1 (wrap), then 3.
- Reset mid-flight: assert rst with 2 entries in flight -> out_valid and busy drop immediately. After release, the first new grant goes to the lowest valid index.
